// File: rtl/mem_data_cache.sv
// mem_data_cache
//   Direct-mapped, write-through, no-write-allocate data cache for the MEM
//   stage. One 32-bit word per line, 2^IDX_BITS lines. Read misses fill the
//   line from main memory; every store is written through to memory and only
//   updates the line if it is already resident.
//
// Optional feature macro: DCACHE_STATS_EN
//   When defined, hit_count / miss_count are live saturating counters.
//   When undefined, both ports are tied to zero.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   m_ctlout[2:0]       {branch (unused), memread, memwrite}
//   alu_result[31:0]    byte address (bits [1:0] ignored)
//   rdata2out[31:0]     store data
//   data_hit            1 = access complete / no access, 0 = stall upstream
//   read_data[31:0]     load data, zero unless a completed read
//   mem_req, mem_we     main-memory request and direction (1 = write)
//   mem_addr[29:0]      main-memory word address
//   mem_wdata[31:0]     main-memory write data
//   mem_rdata[31:0]     main-memory read data, valid with mem_ack
//   mem_ack             one-cycle completion pulse
//   hit_count, miss_count  statistics counters
module mem_data_cache #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  m_ctlout,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    output logic        data_hit,
    output logic [31:0] read_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int LINES = 1 << IDX_BITS;
    localparam int TAG_W = 30 - IDX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];
    logic                wr_done;

    logic                is_read;
    logic                is_write;
    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                lookup_hit;
    logic [IDX_BITS-1:0] lat_idx;
    logic [TAG_W-1:0]    lat_tag;
    logic                unused_bits;

    // memread together with memwrite is handled as a store
    assign is_write   = m_ctlout[0];
    assign is_read    = m_ctlout[1] & ~m_ctlout[0];
    assign req_idx    = alu_result[IDX_BITS+1:2];
    assign req_tag    = alu_result[31:IDX_BITS+2];
    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // Outside IDLE only the latched request address is used
    assign lat_idx    = mem_addr[IDX_BITS-1:0];
    assign lat_tag    = mem_addr[29:IDX_BITS];

    assign unused_bits = ^{m_ctlout[2], alu_result[1:0]};

    always_comb begin
        data_hit  = 1'b0;
        read_data = 32'h0;
        if (!rst_n) begin
            data_hit = 1'b1;
        end else if (state == IDLE) begin
            if (is_write) begin
                // A store completes only via the flag left behind by WRITE
                data_hit = wr_done;
            end else if (is_read) begin
                data_hit = lookup_hit;
                if (lookup_hit)
                    read_data = data_mem[req_idx];
            end else begin
                data_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            wr_done   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_hit) begin
                        wr_done <= 1'b0;
                    end else if (is_write) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= alu_result[31:2];
                        mem_wdata <= rdata2out;
                        wr_done   <= 1'b0;
                        state     <= WRITE;
                    end else if (is_read) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= alu_result[31:2];
                        wr_done  <= 1'b0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid[lat_idx] <= 1'b1;
                        mem_req        <= 1'b0;
                        state          <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        wr_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= mem_rdata;
        end else if (state == WRITE && mem_ack && valid[lat_idx] &&
                     tag_mem[lat_idx] == lat_tag) begin
            data_mem[lat_idx] <= mem_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
        end else if (state == IDLE && is_read) begin
            if (data_hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'h1;
            // A read that does not hit in IDLE always moves to FILL
            if (!data_hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'h1;
        end
    end
`else
    assign hit_count  = 16'h0;
    assign miss_count = 16'h0;
`endif

endmodule

// File: tb/tb_mem_data_cache.sv
module tb_mem_data_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_ctlout;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic        data_hit;
    logic [31:0] read_data;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        resp_ack;
    logic        stray_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_delay = 1;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem_model [bit [29:0]];

    assign mem_ack = resp_ack | stray_ack;

    always #5 clk = ~clk;

    mem_data_cache #(.IDX_BITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_ctlout   (m_ctlout),
        .alu_result (alu_result),
        .rdata2out  (rdata2out),
        .data_hit   (data_hit),
        .read_data  (read_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory responder: compares each request with the scoreboard, then acks
    // after ack_delay further cycles unless reset intervenes.
    initial begin
        req_t exp_req;
        bit   abort;
        int   guard;
        resp_ack  = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", {31'b0, mem_req}, 32'h0);
                    guard = 0;
                    while (mem_req && guard < 50) begin
                        @(negedge clk);
                        guard++;
                    end
                end else begin
                    exp_req = req_q.pop_front();
                    chk("req_we", {31'b0, mem_we}, {31'b0, exp_req.we});
                    chk("req_addr", {2'b0, mem_addr}, {2'b0, exp_req.addr});
                    if (exp_req.we)
                        chk("req_wdata", mem_wdata, exp_req.wdata);
                    abort = 1'b0;
                    for (int i = 0; i < ack_delay; i++) begin
                        @(posedge clk);
                        if (!rst_n) abort = 1'b1;
                    end
                    if (!abort && rst_n) begin
                        #1;
                        resp_ack = 1'b1;
                        if (exp_req.we)
                            mem_model[exp_req.addr] = mem_wdata;
                        else
                            mem_rdata = mem_model.exists(exp_req.addr) ?
                                        mem_model[exp_req.addr] : 32'h0;
                        @(posedge clk);
                        #1;
                        resp_ack  = 1'b0;
                        mem_rdata = 32'hBAD0_BAD0;
                    end
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic do_access(input string tag, input logic [2:0] ctl,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int dly, input bit exp_miss,
                             input logic [31:0] exp_rd);
        int   low;
        logic is_wr;
        logic is_rd;
        req_t r;
        is_wr = ctl[0];
        is_rd = ctl[1] & ~ctl[0];
        ack_delay = dly;
        if (is_wr || exp_miss) begin
            r.we = is_wr; r.addr = addr[31:2]; r.wdata = wd;
            req_q.push_back(r);
        end
        if (is_rd) rd_q.push_back(exp_rd);
        m_ctlout   = ctl;
        alu_result = addr;
        rdata2out  = wd;
        low = 0;
        @(negedge clk);
        while (!data_hit && low < 100) begin
            low++;
            @(negedge clk);
        end
        chk({tag, "_stall"}, low, (is_wr || exp_miss) ? dly + 2 : 0);
        if (is_rd)
            chk({tag, "_rdata"}, read_data, rd_q.pop_front());
        chk({tag, "_req_low"}, {31'b0, mem_req}, 32'h0);
        @(posedge clk);
        #1;
        m_ctlout = 3'b000;
    endtask

    initial begin
        logic [15:0] exp_hits;
        logic [15:0] exp_miss;
        int          wait_cnt;

        rst_n      = 1'b0;
        m_ctlout   = 3'b000;
        alu_result = 32'h0;
        rdata2out  = 32'h0;
        stray_ack  = 1'b0;

        mem_model[30'h10]  = 32'hDEAD_BEEF;
        mem_model[30'h00]  = 32'hA0A0_0000;
        mem_model[30'h20]  = 32'h8080_8080;
        mem_model[30'h11]  = 32'h4444_4444;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_hit", {31'b0, data_hit}, 32'h1);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_hits", {16'b0, hit_count}, 32'h0);
        chk("rst_misses", {16'b0, miss_count}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss then warm hit on 0x40
        do_access("cold_rd",  3'b010, 32'h0000_0040, 32'h0, 3, 1'b1, 32'hDEAD_BEEF);
        do_access("warm_rd",  3'b010, 32'h0000_0040, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
`ifdef DCACHE_STATS_EN
        exp_hits = 16'd2; exp_miss = 16'd1;
`else
        exp_hits = 16'd0; exp_miss = 16'd0;
`endif
        chk("hit_count", {16'b0, hit_count}, {16'b0, exp_hits});
        chk("miss_count", {16'b0, miss_count}, {16'b0, exp_miss});

        // Store hit updates the resident line
        do_access("st_hit",   3'b001, 32'h0000_0040, 32'h1234_5678, 1, 1'b1, 32'h0);
        do_access("rd_upd",   3'b010, 32'h0000_0040, 32'h0, 1, 1'b0, 32'h1234_5678);

        // Conflict eviction on index 0
        do_access("rd_0",     3'b010, 32'h0000_0000, 32'h0, 2, 1'b1, 32'hA0A0_0000);
        do_access("rd_0_hit", 3'b010, 32'h0000_0000, 32'h0, 2, 1'b0, 32'hA0A0_0000);
        do_access("rd_80",    3'b010, 32'h0000_0080, 32'h0, 1, 1'b1, 32'h8080_8080);
        do_access("rd_0_ev",  3'b010, 32'h0000_0000, 32'h0, 4, 1'b1, 32'hA0A0_0000);

        // Store miss does not allocate; memread+memwrite counts as a store
        do_access("st_miss",  3'b011, 32'h0000_0200, 32'h55AA_55AA, 2, 1'b1, 32'h0);
        do_access("rd_200",   3'b010, 32'h0000_0200, 32'h0, 1, 1'b1, 32'h55AA_55AA);
        do_access("rd_200_h", 3'b010, 32'h0000_0200, 32'h0, 1, 1'b0, 32'h55AA_55AA);

        // Stray ack while idle must not disturb anything
        stray_ack = 1'b1;
        @(negedge clk);
        chk("stray_hit", {31'b0, data_hit}, 32'h1);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        do_access("rd_stray", 3'b010, 32'h0000_0200, 32'h0, 1, 1'b0, 32'h55AA_55AA);

        // Reset in the middle of a fill
        ack_delay = 20;
        begin
            req_t r;
            r.we = 1'b0; r.addr = 30'h11; r.wdata = 32'h0;
            req_q.push_back(r);
        end
        m_ctlout   = 3'b010;
        alu_result = 32'h0000_0044;
        wait_cnt = 0;
        while (!mem_req && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("mid_fill_req", {31'b0, mem_req}, 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_fill_req", {31'b0, mem_req}, 32'h0);
        chk("rst_fill_hit", {31'b0, data_hit}, 32'h1);
        chk("rst_fill_rdata", read_data, 32'h0);
        m_ctlout = 3'b000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_access("rd_after_rst", 3'b010, 32'h0000_0200, 32'h0, 1, 1'b1, 32'h55AA_55AA);
        chk("req_q_empty", req_q.size(), 32'h0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
